ccff_chain_loader: RTL and testbench

Configuration-chain driver for the physical logic tiles: the transmit end of the `ccff_head`/`ccff_tail` scan protocol. It accepts a bitstream as a word stream, serializes it into the head of a tile configuration chain (for example a ble6 chain: 64 LUT bits + 2 output-mux bits = 66), then recirculates the chain once to read it back and verify it against a shadow copy. It sits between the bitstream source (JTAG/SPI bridge) and the `ccff_head` of the first tile, and observes `ccff_tail` of the last tile.

---
 rtl/ccff_loader_pkg.sv | 16 +
 rtl/ccff_bit_serializer.sv | 51 +++++
 rtl/ccff_chain_loader.sv | 129 ++++++++++++
 tb/tb_ccff_chain_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_DONE
  } state_e;

  // Bits needed to index 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ccff_bit_serializer.sv
// One-word buffer that turns the bitstream word stream into single bits, LSB first.
module ccff_bit_serializer
  import ccff_loader_pkg::*;
#(
  parameter int unsigned WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              clear,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              last,
  output logic              bit_valid,
  output logic              bit_data,
  input  logic              bit_take
);

  localparam int unsigned IW = cnt_w(WORD_W);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_W - 1);

  logic [WORD_W-1:0] buf_q;
  logic              buf_valid_q;
  logic [IW-1:0]     idx_q;

  assign s_ready   = enable & ~buf_valid_q;
  assign bit_valid = buf_valid_q;
  assign bit_data  = buf_q[0];

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      idx_q       <= '0;
    end else if (clear) begin
      buf_valid_q <= 1'b0;
      idx_q       <= '0;
    end else if (s_valid && s_ready) begin
      buf_q       <= s_data;
      buf_valid_q <= 1'b1;
      idx_q       <= '0;
    end else if (bit_take && buf_valid_q) begin
      buf_q <= buf_q >> 1;
      idx_q <= idx_q + 1'b1;
      // The final chain bit also drops the buffer so leftover bits are discarded.
      if (last || idx_q == LAST_IDX) buf_valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a tile configuration chain through ccff_head and verifies it by recirculating
// the chain once against a shadow copy of the shifted bits.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 66,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned VERIFY_EN = 1
) (
  input  logic                           prog_clk,
  input  logic                           pReset_n,
  input  logic                           start,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [WORD_W-1:0]              s_data,
  output logic                           ccff_head,
  input  logic                           ccff_tail,
  output logic                           shift_en,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [$clog2(CHAIN_LEN+1)-1:0] mismatch_cnt
);

  localparam int unsigned CW = cnt_w(CHAIN_LEN);
  localparam int unsigned MW = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
  localparam logic [MW-1:0] MAX_ERR  = MW'(CHAIN_LEN);

  state_e               state_q, state_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [MW-1:0]        err_q, err_d;
  logic                 pass_q, pass_d;
  logic [CHAIN_LEN-1:0] shadow_q;

  logic bit_valid, bit_data, bit_take, at_last, mismatch, result;

  assign at_last      = (bit_cnt_q == LAST_BIT);
  assign bit_take     = (state_q == ST_LOAD) & bit_valid;
  assign mismatch     = (ccff_tail != shadow_q[bit_cnt_q]);
  assign result       = (VERIFY_EN == 0) ? 1'b1 : (err_q == '0);
  assign mismatch_cnt = err_q;

  ccff_bit_serializer #(
    .WORD_W(WORD_W)
  ) u_serializer (
    .prog_clk (prog_clk),
    .pReset_n (pReset_n),
    .clear    ((state_q == ST_IDLE) & start),
    .enable   (state_q == ST_LOAD),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .last     (at_last),
    .bit_valid(bit_valid),
    .bit_data (bit_data),
    .bit_take (bit_take)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    err_d     = err_q;
    pass_d    = pass_q;
    shift_en  = 1'b0;
    ccff_head = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = pass_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          bit_cnt_d = '0;
          err_d     = '0;
          pass_d    = 1'b0;
        end
      end
      ST_LOAD: begin
        busy      = 1'b1;
        shift_en  = bit_valid;
        ccff_head = bit_data;
        if (bit_valid) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (at_last) begin
            bit_cnt_d = '0;
            state_d   = (VERIFY_EN != 0) ? ST_VERIFY : ST_DONE;
          end
        end
      end
      ST_VERIFY: begin
        busy      = 1'b1;
        shift_en  = 1'b1;
        // Tail fed straight back to head so the readback leaves the chain intact.
        ccff_head = ccff_tail;
        if (mismatch && err_q != MAX_ERR) err_d = err_q + 1'b1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (at_last) begin
          bit_cnt_d = '0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        pass    = result;
        pass_d  = result;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      err_q     <= '0;
      pass_q    <= 1'b0;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
      if (bit_take) shadow_q[bit_cnt_q] <= bit_data;
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench: two loaders (verify on/off) share stimulus, each drives its own model chain.
module tb_ccff_chain_loader;

  localparam int unsigned N  = 66;
  localparam int unsigned W  = 8;
  localparam int unsigned NW = 9;
  localparam int unsigned MW = 7;

  logic         prog_clk = 1'b0;
  logic         pReset_n = 1'b1;
  logic         start    = 1'b0;
  logic         s_valid  = 1'b0;
  logic [W-1:0] s_data   = '0;
  logic [1:0]   s_ready, ccff_head, shift_en, busy, done, pass;
  logic [MW-1:0] mcnt0, mcnt1;

  logic [N-1:0] chain0 = '0;
  logic [N-1:0] chain1 = '0;
  logic         inject = 1'b0;
  int           cnt0   = 0;

  typedef struct {
    logic         ok;
    int           err;
    logic [N-1:0] chain;
    int           hs;
    int           shifts;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   checks = 0;
  int   errors = 0;
  int   hs[2] = '{0, 0};
  int   sh[2] = '{0, 0};
  logic prev_sh[2] = '{1'b0, 1'b0};
  int   done_cnt[2] = '{0, 0};
  logic [W-1:0] wds[NW];

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(N), .WORD_W(W), .VERIFY_EN(1)) dut0 (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start), .s_valid(s_valid),
    .s_ready(s_ready[0]), .s_data(s_data), .ccff_head(ccff_head[0]), .ccff_tail(chain0[0]),
    .shift_en(shift_en[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .mismatch_cnt(mcnt0)
  );

  ccff_chain_loader #(.CHAIN_LEN(N), .WORD_W(W), .VERIFY_EN(0)) dut1 (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start), .s_valid(s_valid),
    .s_ready(s_ready[1]), .s_data(s_data), .ccff_head(ccff_head[1]), .ccff_tail(chain1[0]),
    .shift_en(shift_en[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .mismatch_cnt(mcnt1)
  );

  // Behavioural chain: head enters the far end, flop 0 drives the tail.
  function automatic logic [N-1:0] shift_chain(input logic [N-1:0] c, input logic head,
                                               input logic upset);
    logic [N-1:0] n;
    n = {head, c[N-1:1]};
    if (upset) n[10] = 1'b1;
    return n;
  endfunction

  // Fault model: flop 10 of chain0 flips high on the final load shift.
  always @(posedge prog_clk) begin
    if (start && !busy[0]) cnt0 <= 0;
    else if (shift_en[0]) cnt0 <= cnt0 + 1;
    if (shift_en[0]) chain0 <= shift_chain(chain0, ccff_head[0], inject && cnt0 == N - 1);
    if (shift_en[1]) chain1 <= shift_chain(chain1, ccff_head[1], 1'b0);
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_outs"}, N'({s_ready, ccff_head, shift_en, busy, done, pass}), '0);
    chk({name, "_mcnt"}, N'({mcnt0, mcnt1}), '0);
  endtask

  // Monitor: per-run handshake/shift counters, scoreboard pop on each done pulse.
  initial begin
    exp_t         e;
    logic [MW-1:0] mc;
    logic [N-1:0] ch;
    forever begin
      @(negedge prog_clk);
      for (int m = 0; m < 2; m++) begin
        if (!pReset_n || (start && !busy[m])) begin
          hs[m] = 0;
          sh[m] = 0;
        end else begin
          if (s_valid && s_ready[m]) hs[m]++;
          if (shift_en[m]) sh[m]++;
        end
        if (done[m]) begin
          done_cnt[m]++;
          mc = (m == 0) ? mcnt0 : mcnt1;
          ch = (m == 0) ? chain0 : chain1;
          if ((m == 0 ? sb0.size() : sb1.size()) == 0) begin
            chk($sformatf("unexpected_done%0d", m), 1, 0);
          end else begin
            if (m == 0) e = sb0.pop_front();
            else e = sb1.pop_front();
            chk($sformatf("pass%0d", m), N'(pass[m]), N'(e.ok));
            chk($sformatf("mismatch_cnt%0d", m), N'(mc), N'(e.err));
            chk($sformatf("chain%0d", m), ch, e.chain);
            chk($sformatf("handshakes%0d", m), N'(hs[m]), N'(e.hs));
            chk($sformatf("shifts%0d", m), N'(sh[m]), N'(e.shifts));
            chk($sformatf("done_latency%0d", m), N'(prev_sh[m]), 1);
          end
        end
        prev_sh[m] = shift_en[m];
      end
    end
  end

  task automatic wait_ready(input string name);
    for (int c = 0; c < 100; c++) begin
      @(negedge prog_clk);
      if (s_ready[0]) break;
    end
    if (!s_ready[0]) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic run(input bit fault, input bit stall, input bit extra);
    logic [N-1:0] pat, snap;
    exp_t e0, e1;
    int   base0, base1;
    bit   seen;
    for (int k = 0; k < N; k++) pat[k] = wds[k / W][k % W];
    e0.chain = pat; e0.err = 0; e0.hs = NW; e0.shifts = 2 * N;
    if (fault) begin
      e0.err       = pat[10] ? 0 : 1;
      e0.chain[10] = 1'b1;
    end
    e0.ok = (e0.err == 0);
    e1.chain = pat; e1.err = 0; e1.ok = 1'b1; e1.hs = NW; e1.shifts = N;
    sb0.push_back(e0);
    sb1.push_back(e1);
    inject = fault;
    base0  = done_cnt[0];
    base1  = done_cnt[1];
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
    for (int i = 0; i < int'(NW); i++) begin
      if (stall && i == 4) begin
        s_valid = 1'b0;
        wait_ready("stall_drain");
        snap = chain0;
        for (int j = 0; j < 5; j++) begin
          if (j > 0) @(negedge prog_clk);
          chk("stall_shift_en", N'(shift_en), '0);
          chk("stall_chain", chain0, snap);
        end
        @(posedge prog_clk); #1;
      end
      if (extra && i == 2) begin
        start = 1'b1;
        @(posedge prog_clk); #1 start = 1'b0;
      end
      s_valid = 1'b1;
      s_data  = wds[i];
      wait_ready("handshake");
      @(posedge prog_clk); #1;
    end
    s_valid = extra;
    s_data  = 8'hFF;
    if (extra) begin
      seen = 1'b0;
      repeat (150) begin
        @(negedge prog_clk);
        if (|s_ready) seen = 1'b1;
      end
      chk("extra_word_refused", N'(seen), 0);
    end
    s_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done_cnt[0] > base0 && done_cnt[1] > base1) break;
      @(negedge prog_clk);
    end
    repeat (5) @(negedge prog_clk);
    chk("done_count0", N'(done_cnt[0] - base0), 1);
    chk("done_count1", N'(done_cnt[1] - base1), 1);
    inject = 1'b0;
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < int'(NW); i++)
      wds[i] = (mode == 0) ? 8'hA5 : (mode == 1) ? 8'h00 : W'($urandom);
  endtask

  initial begin
    int base;
    #1 pReset_n = 1'b0;
    repeat (3) @(posedge prog_clk);
    #1 check_quiet("reset");
    pReset_n = 1'b1;

    fill(0); run(1'b0, 1'b0, 1'b0);   // basic load and verify
    fill(1); run(1'b1, 1'b0, 1'b0);   // injected fault, all-zero data
    fill(0); run(1'b0, 1'b1, 1'b0);   // source stall between words 3 and 4
    fill(2); run(1'b0, 1'b0, 1'b1);   // stray start and a 10th word

    // Reset in the middle of the load
    fill(2);
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
    s_valid = 1'b1;
    s_data  = wds[0];
    for (int c = 0; c < 200; c++) begin
      if (cnt0 >= 30) break;
      @(posedge prog_clk); #2;
    end
    chk("reached_bit30", N'(cnt0 >= 30), 1);
    base = done_cnt[0] + done_cnt[1];
    pReset_n = 1'b0;
    #1 check_quiet("reset_mid");
    s_valid = 1'b0;
    repeat (3) @(posedge prog_clk);
    #1 pReset_n = 1'b1;
    chk("no_done_after_abort", N'(done_cnt[0] + done_cnt[1] - base), 0);
    run(1'b0, 1'b0, 1'b0);

    fill(2); run(1'b1, 1'b0, 1'b0);   // random data with the flop-10 upset
    fill(2); run(1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
